dm_be: RTL

DM_BE -- requirements
Module: dm_be

---
 rtl/dm_be.sv | 119 +++++++++++
 1 files changed

// File: rtl/dm_be.sv
`default_nettype none
// ============================================================================
// Module   : dm_be
// Brief    : Byte-enabled data memory with a clear-on-reset engine.
// Revision : 1.0
// ============================================================================
module dm_be #(
    parameter int DEPTH = 3072,
    parameter int IDX_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] dout,
    output logic        busy,
    output logic        err
);

    localparam int             CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0]     c_CLEAR  = 1'b0;
    localparam logic [0:0]     c_READY  = 1'b1;
    localparam logic [IDX_W:0] c_DEPTH  = (IDX_W + 1)'(DEPTH);
    localparam logic [CW-1:0]  c_LAST   = CW'(DEPTH - 1);

    logic [0:0]       r_state;
    logic [CW-1:0]    r_clr_idx;
    logic [31:0]      r_mem [DEPTH];

    logic [IDX_W-1:0] w_idx;
    logic             w_range_err;
    logic             w_align_err;
    logic [CW-1:0]    w_word_idx;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_we;
    logic             w_unused_addr_hi;

    assign w_idx            = addr[IDX_W+1:2];
    assign w_unused_addr_hi = ^addr[31:IDX_W+2];
    assign w_range_err      = ({1'b0, w_idx} >= c_DEPTH);
    assign w_align_err      = (size == 2'b11)
                            || ((size == 2'b01) && addr[0])
                            || ((size == 2'b10) && (addr[1:0] != 2'b00));
    assign err              = w_range_err || w_align_err;
    assign busy             = (r_state == c_CLEAR);
    assign w_we             = MemWrite && !busy && !err;

    // Out-of-range indices are steered to word 0 so the read never leaves the array.
    assign w_word_idx = w_range_err ? '0 : CW'(w_idx);
    assign w_word     = r_mem[w_word_idx];
    assign w_byte     = w_word[{addr[1:0], 3'b000} +: 8];
    assign w_half     = w_word[{addr[1], 4'b0000} +: 16];

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = din;
        case (size)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{din[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{din[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_comb begin
        dout = '0;
        if (!busy && !err) begin
            case (size)
                2'b00:   dout = {{24{sign_ext & w_byte[7]}}, w_byte};
                2'b01:   dout = {{16{sign_ext & w_half[15]}}, w_half};
                2'b10:   dout = w_word;
                default: dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_CLEAR;
            r_clr_idx <= '0;
        end else if (r_state == c_CLEAR) begin
            if (r_clr_idx == c_LAST) begin
                r_state <= c_READY;
            end else begin
                r_clr_idx <= r_clr_idx + 1'b1;
            end
        end
    end

    // Clear writes win over stores; a store seen during the clear is simply dropped.
    always_ff @(posedge clk) begin
        if (r_state == c_CLEAR) begin
            if (!reset) begin
                r_mem[r_clr_idx] <= '0;
            end
        end else if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_word_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
